multicycle_control_fsm: RTL and testbench

- Multi-cycle successor to the combinational RV32I decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the existing datapath control encodings, gated per state.
- Adds memory ready handshakes, an optional memory-wait timeout trap, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register (IR) and the datapath.

---
 rtl/multicycle_control_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer between the IR and the datapath.
// Adds imem/dmem ready handshakes, optional wait timeout, illegal-opcode trap and instret.
//
// state  | meaning
// FETCH  | imem request; latch IR when imem_ready
// DECODE | latch decode of opcode; illegal opcode traps
// EXEC   | branch retires here; load/store go to MEM; others to WB
// MEM    | dmem request; store retires on dmem_ready, load goes to WB
// WB     | register write and retire
// TRAP   | halted with cause held; left only through rst
module multicycle_control_fsm #(
   parameter int TIMEOUT_CYCLES = 0,
   parameter int INSTRET_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           opcode,
   input  logic                 imem_ready,
   input  logic                 dmem_ready,
   output logic                 imem_req,
   output logic                 dmem_req,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 a_sel,
   output logic                 b_sel,
   output logic [1:0]           alu_op,
   output logic [1:0]           pc_op,
   output logic                 regwrite,
   output logic                 memwrite,
   output logic [1:0]           memtoreg,
   output logic [2:0]           immsrc,
   output logic                 halt,
   output logic [1:0]           trap_cause,
   output logic [INSTRET_W-1:0] instret
);

   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
   localparam int WAIT_W     = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = TIMEOUT_EN ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef struct packed {
      logic       a_sel;
      logic       b_sel;
      logic [1:0] alu_op;
      logic [1:0] pc_op;
      logic [1:0] memtoreg;
      logic [2:0] immsrc;
      logic       is_load;
      logic       is_store;
      logic       is_branch;
   } dec_t;

   state_t            state, state_nxt;
   dec_t              dec, dec_nxt;
   logic              dec_legal;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic              trap_set;
   logic [1:0]        cause_nxt;

   always_comb begin
      dec_nxt   = '0;
      dec_legal = 1'b1;
      case (opcode)
         7'b0110011: begin dec_nxt.alu_op = 2'b10; dec_nxt.immsrc = 3'b101; end
         7'b0010011: begin dec_nxt.b_sel = 1'b1; dec_nxt.alu_op = 2'b11; end
         7'b0000011: begin
            dec_nxt.b_sel    = 1'b1;
            dec_nxt.memtoreg = 2'b01;
            dec_nxt.is_load  = 1'b1;
         end
         7'b0100011: begin
            dec_nxt.b_sel    = 1'b1;
            dec_nxt.immsrc   = 3'b001;
            dec_nxt.is_store = 1'b1;
         end
         7'b1100011: begin
            dec_nxt.alu_op    = 2'b01;
            dec_nxt.pc_op     = 2'b01;
            dec_nxt.immsrc    = 3'b010;
            dec_nxt.is_branch = 1'b1;
         end
         7'b0110111: begin dec_nxt.memtoreg = 2'b10; dec_nxt.immsrc = 3'b100; end
         7'b0010111: begin
            dec_nxt.a_sel  = 1'b1;
            dec_nxt.b_sel  = 1'b1;
            dec_nxt.immsrc = 3'b100;
         end
         7'b1101111: begin
            dec_nxt.pc_op    = 2'b10;
            dec_nxt.memtoreg = 2'b11;
            dec_nxt.immsrc   = 3'b011;
         end
         7'b1100111: begin
            dec_nxt.b_sel    = 1'b1;
            dec_nxt.pc_op    = 2'b11;
            dec_nxt.memtoreg = 2'b11;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_FETCH;
         wait_cnt   <= '0;
         instret    <= '0;
         trap_cause <= 2'b00;
         dec        <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (pc_write)
            instret <= instret + INSTRET_W'(1);
         if (state == S_DECODE)
            dec <= dec_nxt;
         if (trap_set)
            trap_cause <= cause_nxt;
      end
   end

   // Counter stays zero outside FETCH/MEM, so entering either state starts it clean.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = '0;
      trap_set     = 1'b0;
      cause_nxt    = 2'b00;
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      regwrite     = 1'b0;
      memwrite     = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write  = 1'b1;
               state_nxt = S_DECODE;
            end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
               state_nxt = S_TRAP;
               trap_set  = 1'b1;
               cause_nxt = 2'b10;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            if (!dec_legal) begin
               state_nxt = S_TRAP;
               trap_set  = 1'b1;
               cause_nxt = 2'b01;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (dec.is_load || dec.is_store) begin
               state_nxt = S_MEM;
            end else if (dec.is_branch) begin
               pc_write  = 1'b1;
               state_nxt = S_FETCH;
            end else begin
               state_nxt = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            memwrite = dec.is_store;
            if (dmem_ready) begin
               if (dec.is_store) begin
                  pc_write  = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
               state_nxt = S_TRAP;
               trap_set  = 1'b1;
               cause_nxt = 2'b11;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         S_WB: begin
            regwrite  = 1'b1;
            pc_write  = 1'b1;
            state_nxt = S_FETCH;
         end
         S_TRAP:  state_nxt = S_TRAP;
         default: state_nxt = S_FETCH;
      endcase
      // An aborted instruction must not leave a strobe behind in the reset cycle.
      if (rst) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         ir_write = 1'b0;
         pc_write = 1'b0;
         regwrite = 1'b0;
         memwrite = 1'b0;
      end
   end

   assign halt     = (state == S_TRAP);
   assign a_sel    = dec.a_sel;
   assign b_sel    = dec.b_sel;
   assign alu_op   = dec.alu_op;
   assign pc_op    = dec.pc_op;
   assign memtoreg = dec.memtoreg;
   assign immsrc   = dec.immsrc;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: cycle-by-cycle strobe vectors and latched
// select outputs against hand-computed values, including timeouts, traps and wrap.
module tb_multicycle_control_fsm;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_ILL = 7'b0000000;

   // {imem_req, ir_write, dmem_req, memwrite, regwrite, pc_write, halt}
   localparam logic [6:0] V_IDLE  = 7'b0000000;
   localparam logic [6:0] V_FRDY  = 7'b1100000;
   localparam logic [6:0] V_FWAIT = 7'b1000000;
   localparam logic [6:0] V_MRD   = 7'b0010000;
   localparam logic [6:0] V_MWR   = 7'b0011000;
   localparam logic [6:0] V_MWRD  = 7'b0011010;
   localparam logic [6:0] V_WB    = 7'b0000110;
   localparam logic [6:0] V_BR    = 7'b0000010;
   localparam logic [6:0] V_TRAP  = 7'b0000001;

   // {a_sel, b_sel, alu_op, pc_op, memtoreg, immsrc}
   localparam logic [10:0] M_R  = 11'b0_0_10_00_00_101;
   localparam logic [10:0] M_LD = 11'b0_1_00_00_01_000;
   localparam logic [10:0] M_ST = 11'b0_1_00_00_00_001;
   localparam logic [10:0] M_BR = 11'b0_0_01_01_00_010;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, imem_ready, dmem_ready;
   logic [6:0] opcode;
   logic       imem_req, dmem_req, ir_write, pc_write, a_sel, b_sel;
   logic [1:0] alu_op, pc_op, memtoreg, trap_cause;
   logic       regwrite, memwrite, halt;
   logic [2:0] immsrc;
   logic [7:0] instret;

   logic        rst0, imem_ready0, dmem_ready0;
   logic [6:0]  opcode0;
   logic        imem_req0, dmem_req0, ir_write0, pc_write0, a_sel0, b_sel0;
   logic [1:0]  alu_op0, pc_op0, memtoreg0, trap_cause0;
   logic        regwrite0, memwrite0, halt0;
   logic [2:0]  immsrc0;
   logic [31:0] instret0;

   int n_assert = 0;
   int n_fail   = 0;

   multicycle_control_fsm #(.TIMEOUT_CYCLES(4), .INSTRET_W(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write), .pc_write(pc_write),
      .a_sel(a_sel), .b_sel(b_sel), .alu_op(alu_op), .pc_op(pc_op), .regwrite(regwrite),
      .memwrite(memwrite), .memtoreg(memtoreg), .immsrc(immsrc), .halt(halt),
      .trap_cause(trap_cause), .instret(instret)
   );

   // Default parameters: timeout disabled, so an idle imem must never trap.
   multicycle_control_fsm dut0 (
      .clk(clk), .rst(rst0), .opcode(opcode0), .imem_ready(imem_ready0), .dmem_ready(dmem_ready0),
      .imem_req(imem_req0), .dmem_req(dmem_req0), .ir_write(ir_write0), .pc_write(pc_write0),
      .a_sel(a_sel0), .b_sel(b_sel0), .alu_op(alu_op0), .pc_op(pc_op0), .regwrite(regwrite0),
      .memwrite(memwrite0), .memtoreg(memtoreg0), .immsrc(immsrc0), .halt(halt0),
      .trap_cause(trap_cause0), .instret(instret0)
   );

   wire [6:0]  strb = {imem_req, ir_write, dmem_req, memwrite, regwrite, pc_write, halt};
   wire [10:0] muxv = {a_sel, b_sel, alu_op, pc_op, memtoreg, immsrc};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cs(input string tag, input logic [6:0] exp);
      chk(tag, 64'(strb), 64'(exp));
   endtask

   task automatic cyc(input logic im, input logic dm, input logic [6:0] op);
      @(posedge clk); #1;
      imem_ready = im;
      dmem_ready = dm;
      opcode     = op;
      #1;
   endtask

   // One reset cycle (strobes must be quiet), then the first cycle after reset.
   task automatic reset_then(input string tag, input logic im, input logic dm, input logic [6:0] op);
      @(posedge clk); #1;
      rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; #1;
      chk({tag, "_rst_strobes"}, 64'(strb[6:1]), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; imem_ready = im; dmem_ready = dm; opcode = op; #1;
   endtask

   initial begin
      rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = OP_R;
      rst0 = 1'b1; imem_ready0 = 1'b0; dmem_ready0 = 1'b1; opcode0 = OP_R;

      reset_then("init", 1'b1, 1'b1, OP_R);
      rst0 = 1'b0;
      chk("rst_instret", 64'(instret), 64'd0);
      chk("rst_cause", 64'(trap_cause), 64'd0);
      chk("rst_mux", 64'(muxv), 64'd0);

      // R-type, zero wait
      cs("r_fetch", V_FRDY);
      cyc(1'b1, 1'b1, OP_R); cs("r_decode", V_IDLE);
      cyc(1'b1, 1'b1, OP_R); cs("r_exec", V_IDLE); chk("r_mux", 64'(muxv), 64'(M_R));
      cyc(1'b1, 1'b1, OP_R); cs("r_wb", V_WB); chk("r_instret_pre", 64'(instret), 64'd0);

      // Load with dmem_ready in the 4th MEM cycle (last one before timeout)
      cyc(1'b1, 1'b1, OP_LD); cs("ld_fetch", V_FRDY); chk("r_instret", 64'(instret), 64'd1);
      cyc(1'b1, 1'b0, OP_LD); cs("ld_decode", V_IDLE);
      cyc(1'b1, 1'b0, OP_LD); cs("ld_exec", V_IDLE); chk("ld_mux", 64'(muxv), 64'(M_LD));
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, OP_LD); cs("ld_mem_wait", V_MRD);
      end
      cyc(1'b1, 1'b1, OP_LD); cs("ld_mem_done", V_MRD);
      cyc(1'b1, 1'b1, OP_LD); cs("ld_wb", V_WB); chk("ld_mux_wb", 64'(muxv), 64'(M_LD));

      // Store, zero wait
      cyc(1'b1, 1'b1, OP_ST); cs("st_fetch", V_FRDY); chk("ld_instret", 64'(instret), 64'd2);
      cyc(1'b1, 1'b1, OP_ST); cs("st_decode", V_IDLE);
      cyc(1'b1, 1'b1, OP_ST); cs("st_exec", V_IDLE); chk("st_mux", 64'(muxv), 64'(M_ST));
      cyc(1'b1, 1'b1, OP_ST); cs("st_mem", V_MWRD);

      // Branch
      cyc(1'b1, 1'b1, OP_BR); cs("br_fetch", V_FRDY); chk("st_instret", 64'(instret), 64'd3);
      cyc(1'b1, 1'b1, OP_BR); cs("br_decode", V_IDLE);
      cyc(1'b1, 1'b1, OP_BR); cs("br_exec", V_BR); chk("br_mux", 64'(muxv), 64'(M_BR));

      // Illegal opcode
      cyc(1'b1, 1'b1, OP_ILL); cs("ill_fetch", V_FRDY); chk("br_instret", 64'(instret), 64'd4);
      cyc(1'b1, 1'b1, OP_ILL); cs("ill_decode", V_IDLE);
      cyc(1'b1, 1'b1, OP_R); cs("ill_trap", V_TRAP); chk("ill_cause", 64'(trap_cause), 64'd1);
      for (int i = 0; i < 100; i++) begin
         cyc(1'b1, 1'b1, OP_R); cs("ill_hold", V_TRAP);
      end
      chk("ill_instret", 64'(instret), 64'd4);
      chk("ill_cause_held", 64'(trap_cause), 64'd1);

      // imem timeout: four not-ready cycles then TRAP
      reset_then("ito", 1'b0, 1'b1, OP_R);
      cs("ito_f1", V_FWAIT);
      chk("ito_rst_cause", 64'(trap_cause), 64'd0);
      chk("ito_rst_instret", 64'(instret), 64'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, OP_R); cs("ito_fwait", V_FWAIT);
      end
      cyc(1'b0, 1'b1, OP_R); cs("ito_trap", V_TRAP); chk("ito_cause", 64'(trap_cause), 64'd2);

      // Ready in the 4th FETCH cycle wins over the timeout
      reset_then("irdy", 1'b0, 1'b1, OP_R);
      cs("irdy_f1", V_FWAIT);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b1, OP_R); cs("irdy_fwait", V_FWAIT);
      end
      cyc(1'b1, 1'b1, OP_R); cs("irdy_last", V_FRDY);
      cyc(1'b1, 1'b1, OP_R); cs("irdy_decode", V_IDLE); chk("irdy_cause", 64'(trap_cause), 64'd0);
      cyc(1'b1, 1'b1, OP_R); cs("irdy_exec", V_IDLE);
      cyc(1'b1, 1'b1, OP_R); cs("irdy_wb", V_WB);

      // dmem timeout on a load
      cyc(1'b1, 1'b0, OP_LD); cs("dto_fetch", V_FRDY); chk("irdy_instret", 64'(instret), 64'd1);
      cyc(1'b1, 1'b0, OP_LD); cs("dto_decode", V_IDLE);
      cyc(1'b1, 1'b0, OP_LD); cs("dto_exec", V_IDLE);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, OP_LD); cs("dto_mem", V_MRD);
      end
      cyc(1'b1, 1'b1, OP_LD); cs("dto_trap", V_TRAP);
      chk("dto_cause", 64'(trap_cause), 64'd3);
      chk("dto_instret", 64'(instret), 64'd1);

      // Reset in the middle of a store's MEM wait
      reset_then("mid0", 1'b1, 1'b1, OP_ST);
      cs("mid_fetch", V_FRDY);
      cyc(1'b1, 1'b0, OP_ST); cs("mid_decode", V_IDLE);
      cyc(1'b1, 1'b0, OP_ST); cs("mid_exec", V_IDLE);
      cyc(1'b1, 1'b0, OP_ST); cs("mid_mem", V_MWR);
      reset_then("mid", 1'b1, 1'b1, OP_BR);
      cs("mid_after_rst", V_FRDY);
      chk("mid_mux", 64'(muxv), 64'd0);
      chk("mid_instret", 64'(instret), 64'd0);

      // 256 back-to-back branches wrap the 8-bit counter
      for (int i = 1; i < 766; i++) cyc(1'b1, 1'b1, OP_BR);
      chk("wrap_255", 64'(instret), 64'd255);
      cs("wrap_fetch", V_FRDY);
      repeat (3) cyc(1'b1, 1'b1, OP_BR);
      chk("wrap_0", 64'(instret), 64'd0);

      // Timeout-disabled instance has been starved of imem the whole run
      chk("notimeout_halt", 64'(halt0), 64'd0);
      chk("notimeout_req", 64'(imem_req0), 64'd1);
      chk("notimeout_irw", 64'(ir_write0), 64'd0);
      chk("notimeout_instret", 64'(instret0), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
